// File: rtl/memaccess_mc_if.sv
// Request, data-memory and response signals of the multi-cycle memory-access stage.
// The slave modport is the stage itself; the master modport is its environment.
interface memaccess_mc_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              data_req;
  logic              data_ack;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_din;
  logic              data_rd;
  logic [DATA_W-1:0] data_dout;

  logic [DATA_W-1:0] memout;
  logic              resp_valid;
  logic              resp_err;
  logic              resp_ready;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, data_ack, data_dout, resp_ready,
    output req_ready, data_req, data_addr, data_din, data_rd, memout, resp_valid, resp_err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, data_ack, data_dout, resp_ready,
    input  req_ready, data_req, data_addr, data_din, data_rd, memout, resp_valid, resp_err
  );
endinterface

// File: rtl/memaccess_mc.sv
// Multi-cycle LC3 memory-access stage: LD/ST/LDI/STI over a req/ack data memory with a
// per-phase stall timeout and a valid/ready response towards writeback.
module memaccess_mc #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input logic           clock,
  input logic           reset,
  memaccess_mc_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StInd, StAcc, StResp} state_e;

  localparam logic [1:0] OpSt  = 2'b01;
  localparam logic [1:0] OpSti = 2'b11;
  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              data_req_q, data_req_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [DATA_W-1:0] data_din_q, data_din_d;
  logic              data_rd_q, data_rd_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic              req_ready;
  logic [TO_W-1:0]   cnt_inc;
  logic              timeout_hit;
  logic [ADDR_W-1:0] ptr;

  assign req_ready   = (state_q == StIdle) & ~reset;
  assign cnt_inc     = cnt_q + TO_W'(1);
  // An ack in the same cycle takes priority over this, so the last stalled cycle still succeeds.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TimeoutVal);
  assign ptr         = ADDR_W'(bus.data_dout);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    data_req_d   = data_req_q;
    data_addr_d  = data_addr_q;
    data_din_d   = data_din_q;
    data_rd_d    = data_rd_q;
    memout_d     = memout_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready) begin
          op_d        = bus.req_op;
          wdata_d     = bus.req_wdata;
          data_req_d  = 1'b1;
          data_addr_d = bus.req_addr;
          data_rd_d   = 1'b1;
          cnt_d       = '0;
          if (bus.req_op == OpSt) begin
            data_rd_d  = 1'b0;
            data_din_d = bus.req_wdata;
          end
          state_d = bus.req_op[1] ? StInd : StAcc;
        end
      end
      StInd, StAcc: begin
        if (bus.data_ack) begin
          cnt_d = '0;
          if (state_q == StInd) begin
            // Pointer fetched; second phase follows back-to-back with data_req held high.
            data_addr_d = ptr;
            data_rd_d   = (op_q != OpSti);
            if (op_q == OpSti) begin
              data_din_d = wdata_q;
            end
            state_d = StAcc;
          end else begin
            if (!op_q[0]) begin
              memout_d = bus.data_dout;
            end
            data_req_d   = 1'b0;
            data_rd_d    = 1'b1;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            state_d      = StResp;
          end
        end else if (timeout_hit) begin
          cnt_d        = '0;
          data_req_d   = 1'b0;
          data_rd_d    = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      wdata_q      <= '0;
      data_req_q   <= 1'b0;
      data_addr_q  <= '0;
      data_din_q   <= '0;
      data_rd_q    <= 1'b1;
      memout_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      data_req_q   <= data_req_d;
      data_addr_q  <= data_addr_d;
      data_din_q   <= data_din_d;
      data_rd_q    <= data_rd_d;
      memout_q     <= memout_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.data_req   = data_req_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_din   = data_din_q;
  assign bus.data_rd    = data_rd_q;
  assign bus.memout     = memout_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;

endmodule
